// File: rtl/mul_add.sv
// mul_add: sequential shift-add multiply-accumulate, result = A*B + C.
//
// Companion to the divider: feeding it {divisor, quotient, remainder}
// rebuilds the dividend. It uses the same start/finish handshake as the
// divider. With CONST_TIME=0 it stops as soon as the remaining multiplier
// bits are all zero. That exposes a data-dependent timing leak for the
// side-channel experiments. CONST_TIME=1 is the reference behaviour.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   multiplicand operand A, captured when start is accepted
//   multiplier   operand B, captured when start is accepted
//   addend       accumulator seed C (zero-extended), captured with A and B
//   result       A*B+C, registered, updated only on completion
//   finish       one-cycle completion pulse, registered
//   busy         high while the FSM is not IDLE
//   cycles       iterations used by the last completed operation
module mul_add #(
    parameter int WIDTH      = 8,
    parameter bit CONST_TIME = 1'b1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic [2*WIDTH-1:0] result,
    output logic               finish,
    output logic               busy,
    output logic [CW-1:0]      cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               finish_q, finish_d;
    logic [CW-1:0]      cycles_q, cycles_d;

    logic [2*WIDTH-1:0] acc_sum;
    logic [CW-1:0]      cnt_inc;
    logic               last_iter;

    // The accumulator is 2*WIDTH bits. The largest value is
    // (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so no carry-out is needed.
    assign acc_sum = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    assign cnt_inc = cnt_q + CW'(1);

    // In early-exit mode the run ends once no set multiplier bits remain
    // after this iteration. B=0 therefore still costs one iteration.
    assign last_iter = (cnt_q == CW'(WIDTH - 1)) ||
                       (!CONST_TIME && ((b_sh_q >> 1) == '0));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cycles_d = cycles_q;
        finish_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = {{WIDTH{1'b0}}, multiplicand};
                    b_sh_d  = multiplier;
                    acc_d   = {{WIDTH{1'b0}}, addend};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_sum;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_inc;
                if (last_iter) begin
                    result_d = acc_sum;
                    cycles_d = cnt_inc;
                    finish_d = 1'b1;
                    state_d  = DONE;
                end
            end
            // DONE lasts one cycle. start is deliberately ignored here.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            finish_q <= finish_d;
            cycles_q <= cycles_d;
        end
    end

    assign result = result_q;
    assign finish = finish_q;
    assign cycles = cycles_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mul_add.sv
// Testbench for mul_add.
// Two instances share one set of operand inputs:
//   dut_c runs with CONST_TIME=1.
//   dut_v runs with CONST_TIME=0 (variable time).
module tb_mul_add;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_c = 1'b0;
    logic        start_v = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic [7:0]  c_in = '0;

    logic [15:0] res_c, res_v;
    logic        fin_c, fin_v;
    logic        busy_c, busy_v;
    logic [3:0]  cyc_c, cyc_v;

    int errors = 0;
    int checks = 0;

    mul_add #(.WIDTH(8), .CONST_TIME(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
        .multiplicand(a_in), .multiplier(b_in), .addend(c_in),
        .result(res_c), .finish(fin_c), .busy(busy_c), .cycles(cyc_c)
    );

    mul_add #(.WIDTH(8), .CONST_TIME(1'b0)) dut_v (
        .clk(clk), .rst_n(rst_n), .start(start_v),
        .multiplicand(a_in), .multiplier(b_in), .addend(c_in),
        .result(res_v), .finish(fin_v), .busy(busy_v), .cycles(cyc_v)
    );

    always #5 clk = ~clk;

    // Runs one operation on the selected instance.
    // The start-sample edge is E. Sample i is taken #1 after edge E+i.
    // lat is the sample index of the first finish, or -1 if finish never rose.
    task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, output int lat, output int busy_cnt,
                          output int fin_cnt, output logic [15:0] res,
                          output logic [3:0] cyc);
        @(negedge clk);
        a_in = a; b_in = b; c_in = c;
        if (sel) start_v = 1'b1; else start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0; start_v = 1'b0;
        lat = -1; busy_cnt = 0; fin_cnt = 0; res = '0; cyc = '0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (sel ? busy_v : busy_c) busy_cnt++;
            if (sel ? fin_v : fin_c) begin
                fin_cnt++;
                if (lat < 0) begin
                    lat = i;
                    res = sel ? res_v : res_c;
                    cyc = sel ? cyc_v : cyc_c;
                end
            end
            if (lat >= 0 && i >= lat + 2) break;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (res_c !== 16'd0 || fin_c !== 1'b0 || busy_c !== 1'b0 || cyc_c !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_c: got res=%0d fin=%b busy=%b cyc=%0d expected 0/0/0/0",
                     res_c, fin_c, busy_c, cyc_c);
        end
        checks++;
        if (res_v !== 16'd0 || fin_v !== 1'b0 || busy_v !== 1'b0 || cyc_v !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_v: got res=%0d fin=%b busy=%b cyc=%0d expected 0/0/0/0",
                     res_v, fin_v, busy_v, cyc_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_const_time();
        int lat, bc, fc;
        logic [15:0] res;
        logic [3:0] cyc;
        run_op(1'b0, 8'd12, 8'd2, 8'd10, lat, bc, fc, res, cyc);
        checks++; if (res !== 16'd34) begin errors++; $display("[TB] FAIL ct_res1: got %0d expected 34", res); end
        checks++; if (cyc !== 4'd8) begin errors++; $display("[TB] FAIL ct_cyc1: got %0d expected 8", cyc); end
        checks++; if (lat != 8) begin errors++; $display("[TB] FAIL ct_lat1: got %0d expected 8", lat); end
        checks++; if (fc != 1) begin errors++; $display("[TB] FAIL ct_finpulses1: got %0d expected 1", fc); end
        checks++; if (bc != 9) begin errors++; $display("[TB] FAIL ct_busy1: got %0d expected 9", bc); end
        run_op(1'b0, 8'd255, 8'd255, 8'd255, lat, bc, fc, res, cyc);
        checks++; if (res !== 16'hFF00) begin errors++; $display("[TB] FAIL ct_res_max: got %0d expected 65280", res); end
        checks++; if (cyc !== 4'd8) begin errors++; $display("[TB] FAIL ct_cyc_max: got %0d expected 8", cyc); end
    endtask

    task automatic test_early_exit();
        int lat, bc, fc;
        logic [15:0] res;
        logic [3:0] cyc;
        run_op(1'b1, 8'd12, 8'd2, 8'd10, lat, bc, fc, res, cyc);
        checks++; if (res !== 16'd34) begin errors++; $display("[TB] FAIL ee_res1: got %0d expected 34", res); end
        checks++; if (cyc !== 4'd2) begin errors++; $display("[TB] FAIL ee_cyc1: got %0d expected 2", cyc); end
        checks++; if (lat != 2) begin errors++; $display("[TB] FAIL ee_lat1: got %0d expected 2", lat); end
        run_op(1'b1, 8'd7, 8'd0, 8'd9, lat, bc, fc, res, cyc);
        checks++; if (res !== 16'd9) begin errors++; $display("[TB] FAIL ee_res_b0: got %0d expected 9", res); end
        checks++; if (cyc !== 4'd1) begin errors++; $display("[TB] FAIL ee_cyc_b0: got %0d expected 1", cyc); end
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL ee_lat_b0: got %0d expected 1", lat); end
        run_op(1'b1, 8'd3, 8'h80, 8'd1, lat, bc, fc, res, cyc);
        checks++; if (res !== 16'd385) begin errors++; $display("[TB] FAIL ee_res_msb: got %0d expected 385", res); end
        checks++; if (cyc !== 4'd8) begin errors++; $display("[TB] FAIL ee_cyc_msb: got %0d expected 8", cyc); end
    endtask

    // start stays high through the whole operation while A and B change.
    // The first op must complete unaffected. The second op is accepted at the
    // IDLE edge after DONE, which is edge E+10.
    task automatic test_start_while_busy();
        int fc = 0;
        int first_fin = -1;
        int second_fin = -1;
        logic [15:0] res1 = '0;
        logic [15:0] res2 = '0;
        @(negedge clk);
        a_in = 8'd3; b_in = 8'd5; c_in = 8'd0; start_c = 1'b1;
        @(posedge clk);
        #1;
        a_in = 8'd100; b_in = 8'd100;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                checks++;
                if (res_c !== 16'hFF00) begin
                    errors++;
                    $display("[TB] FAIL sb_res_hold: got %0d expected 65280", res_c);
                end
            end
            if (i == 9) begin
                checks++;
                if (busy_c !== 1'b0) begin errors++; $display("[TB] FAIL sb_done_ignore: busy got %b expected 0", busy_c); end
            end
            if (i == 10) begin
                checks++;
                if (busy_c !== 1'b1) begin errors++; $display("[TB] FAIL sb_accept: busy got %b expected 1", busy_c); end
                start_c = 1'b0;
            end
            if (fin_c) begin
                if (first_fin < 0) begin first_fin = i; res1 = res_c; fc++; end
                else if (i < 10) fc++;
                else if (second_fin < 0) begin second_fin = i; res2 = res_c; end
            end
        end
        checks++; if (res1 !== 16'd15) begin errors++; $display("[TB] FAIL sb_res1: got %0d expected 15", res1); end
        checks++; if (first_fin != 8) begin errors++; $display("[TB] FAIL sb_lat1: got %0d expected 8", first_fin); end
        checks++; if (fc != 1) begin errors++; $display("[TB] FAIL sb_pulses: got %0d expected 1", fc); end
        checks++; if (second_fin != 18) begin errors++; $display("[TB] FAIL sb_lat2: got %0d expected 18", second_fin); end
        checks++; if (res2 !== 16'd10000) begin errors++; $display("[TB] FAIL sb_res2: got %0d expected 10000", res2); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, bc, fc;
        logic [15:0] res;
        logic [3:0] cyc;
        @(negedge clk);
        a_in = 8'd200; b_in = 8'd200; c_in = 8'd1; start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_c !== 16'd0 || fin_c !== 1'b0 || busy_c !== 1'b0 || cyc_c !== 4'd0) begin
            errors++;
            $display("[TB] FAIL ar_immediate: got res=%0d fin=%b busy=%b cyc=%0d expected 0/0/0/0",
                     res_c, fin_c, busy_c, cyc_c);
        end
        fc = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (fin_c) fc++;
        end
        checks++; if (fc != 0) begin errors++; $display("[TB] FAIL ar_no_finish: got %0d pulses expected 0", fc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 8'd6, 8'd7, 8'd0, lat, bc, fc, res, cyc);
        checks++; if (res !== 16'd42) begin errors++; $display("[TB] FAIL ar_after: got %0d expected 42", res); end
        checks++; if (lat != 8) begin errors++; $display("[TB] FAIL ar_after_lat: got %0d expected 8", lat); end
    endtask

    // Reconstruct dividend = divisor*quotient + remainder.
    // Even vectors go to the constant-time instance, odd ones to the early-exit one.
    task automatic test_divider_loop();
        int lat, bc, fc;
        int exp_cyc;
        logic [15:0] res;
        logic [3:0] cyc;
        logic [7:0] dividend, divisor, q, r;
        for (int n = 0; n < 1000; n++) begin
            dividend = 8'($urandom_range(0, 255));
            divisor  = 8'($urandom_range(1, 255));
            q = dividend / divisor;
            r = dividend % divisor;
            run_op(n[0], divisor, q, r, lat, bc, fc, res, cyc);
            if (n[0]) begin
                exp_cyc = 1;
                for (int k = 0; k < 8; k++) if (q[k]) exp_cyc = k + 1;
            end else begin
                exp_cyc = 8;
            end
            checks++;
            if (res !== {8'd0, dividend}) begin
                errors++;
                $display("[TB] FAIL loop_res[%0d]: got %0d expected %0d", n, res, dividend);
            end
            checks++;
            if (int'(cyc) != exp_cyc || lat != exp_cyc) begin
                errors++;
                $display("[TB] FAIL loop_cyc[%0d]: got cycles=%0d lat=%0d expected %0d", n, cyc, lat, exp_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const_time();
        test_early_exit();
        test_start_while_busy();
        test_async_reset();
        test_divider_loop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
